// File: rtl/stopwatch_arbiter_pkg.sv
// Shared types and constants for the stopwatch arbiter: FSM state encoding
// and the count width of the attached StopTimer.
package stopwatch_arbiter_pkg;

    localparam int SA_CNT_W = 16;

    typedef enum logic [2:0] {
        SA_IDLE   = 3'd0,
        SA_CLEAR  = 3'd1,
        SA_START  = 3'd2,
        SA_RUN    = 3'd3,
        SA_STOP   = 3'd4,
        SA_REPORT = 3'd5
    } sa_state_t;

endpackage

// File: rtl/stopwatch_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping around, plus a flag saying whether any request is present.
module rr_arbiter
    import stopwatch_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [$clog2(NUM_REQ)-1:0] o_winner,
    output logic                       o_any
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [IW:0] NUM_W = (IW+1)'(NUM_REQ);

    logic [IW:0] w_idx;

    // Walk from the farthest offset down to the pointer so the closest hit wins.
    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        w_idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = {1'b0, i_ptr} + (IW+1)'(i);
            if (w_idx >= NUM_W) begin
                w_idx = w_idx - NUM_W;
            end
            if (i_req[w_idx[IW-1:0]]) begin
                o_winner = w_idx[IW-1:0];
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_arbiter.sv
// Round-robin owner of one shared StopTimer: sequences clear/start/stop pulses
// and returns the captured count. Timeout stop is built in with STOPWATCH_ARBITER_TIMEOUT_EN.
module stopwatch_arbiter
    import stopwatch_arbiter_pkg::*;
#(
    parameter int                  NUM_REQ = 4,
    parameter logic [SA_CNT_W-1:0] TIMEOUT = 16'hFFF0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         i_req,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic                       o_tmr_start,
    output logic                       o_tmr_stop,
    output logic                       o_tmr_clear,
    input  logic [SA_CNT_W-1:0]        i_tmr_elapsed,
    output logic                       o_res_valid,
    input  logic                       i_res_ready,
    output logic [$clog2(NUM_REQ)-1:0] o_res_id,
    output logic [SA_CNT_W-1:0]        o_res_count,
    output logic                       o_res_timeout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [IW-1:0] LAST_ID = IW'(NUM_REQ - 1);

    sa_state_t           r_state;
    sa_state_t           w_next_state;
    logic [IW-1:0]       r_owner;
    logic [IW-1:0]       r_ptr;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  w_gnt_d;
    logic                r_tmr_start, r_tmr_stop, r_tmr_clear;
    logic                w_start_d, w_stop_d, w_clear_d;
    logic                r_res_valid;
    logic [IW-1:0]       r_res_id;
    logic [SA_CNT_W-1:0] r_res_count;
    logic                r_res_timeout;
    logic [IW-1:0]       w_winner;
    logic                w_any;
    logic                w_timeout;
    logic                w_run_exit;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_req    (i_req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

`ifdef STOPWATCH_ARBITER_TIMEOUT_EN
    assign w_timeout = (i_tmr_elapsed >= TIMEOUT);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
    assign w_timeout        = 1'b0;
`endif

    assign w_run_exit = !i_req[r_owner] || w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SA_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state plus the next value of every registered command/grant output.
    always_comb begin
        w_next_state = r_state;
        w_gnt_d      = r_gnt;
        w_start_d    = 1'b0;
        w_stop_d     = 1'b0;
        w_clear_d    = 1'b0;
        case (r_state)
            SA_IDLE: begin
                if (w_any) begin
                    w_next_state      = SA_CLEAR;
                    w_clear_d         = 1'b1;
                    w_gnt_d           = '0;
                    w_gnt_d[w_winner] = 1'b1;
                end
            end
            SA_CLEAR: begin
                w_next_state = SA_START;
                w_start_d    = 1'b1;
            end
            SA_START: w_next_state = SA_RUN;
            SA_RUN: begin
                if (w_run_exit) begin
                    w_next_state = SA_STOP;
                    w_stop_d     = 1'b1;
                    w_gnt_d      = '0;
                end
            end
            SA_STOP: w_next_state = SA_REPORT;
            SA_REPORT: begin
                if (r_res_valid && i_res_ready) begin
                    w_next_state = SA_IDLE;
                end
            end
            default: begin
                w_next_state = SA_IDLE;
                w_gnt_d      = '0;
            end
        endcase
    end

    // The count is sampled during STOP, the cycle the stop pulse freezes the timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt         <= '0;
            r_tmr_start   <= 1'b0;
            r_tmr_stop    <= 1'b0;
            r_tmr_clear   <= 1'b0;
            r_owner       <= '0;
            r_ptr         <= '0;
            r_res_valid   <= 1'b0;
            r_res_id      <= '0;
            r_res_count   <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            r_gnt       <= w_gnt_d;
            r_tmr_start <= w_start_d;
            r_tmr_stop  <= w_stop_d;
            r_tmr_clear <= w_clear_d;
            if (r_state == SA_IDLE && w_any) begin
                r_owner       <= w_winner;
                r_res_timeout <= 1'b0;
            end
            if (r_state == SA_RUN && w_run_exit) begin
                r_res_timeout <= w_timeout;
            end
            if (r_state == SA_STOP) begin
                r_res_valid <= 1'b1;
                r_res_id    <= r_owner;
                r_res_count <= i_tmr_elapsed;
            end
            if (r_state == SA_REPORT && r_res_valid && i_res_ready) begin
                r_res_valid <= 1'b0;
                r_ptr       <= (r_owner == LAST_ID) ? '0 : r_owner + IW'(1);
            end
        end
    end

    assign o_gnt         = r_gnt;
    assign o_tmr_start   = r_tmr_start;
    assign o_tmr_stop    = r_tmr_stop;
    assign o_tmr_clear   = r_tmr_clear;
    assign o_res_valid   = r_res_valid;
    assign o_res_id      = r_res_id;
    assign o_res_count   = r_res_count;
    assign o_res_timeout = r_res_timeout;

endmodule

// File: tb/tb_stopwatch_arbiter.sv
// Scoreboard bench for stopwatch_arbiter with a behavioural StopTimer attached;
// the timeout scenario follows STOPWATCH_ARBITER_TIMEOUT_EN.
module tb_stopwatch_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  i_req;
    logic [3:0]  o_gnt;
    logic        o_tmr_start, o_tmr_stop, o_tmr_clear;
    logic [15:0] i_tmr_elapsed;
    logic        o_res_valid;
    logic        i_res_ready;
    logic [1:0]  o_res_id;
    logic [15:0] o_res_count;
    logic        o_res_timeout;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        int id;
        int to;
        int lo;
        int hi;
    } exp_t;
    exp_t sb[$];
    exp_t popped;

    logic [15:0] mCnt;
    logic        mRun;

    stopwatch_arbiter #(.NUM_REQ(4), .TIMEOUT(16'd20)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req         (i_req),
        .o_gnt         (o_gnt),
        .o_tmr_start   (o_tmr_start),
        .o_tmr_stop    (o_tmr_stop),
        .o_tmr_clear   (o_tmr_clear),
        .i_tmr_elapsed (i_tmr_elapsed),
        .o_res_valid   (o_res_valid),
        .i_res_ready   (i_res_ready),
        .o_res_id      (o_res_id),
        .o_res_count   (o_res_count),
        .o_res_timeout (o_res_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural StopTimer: counts while running, freezes on the stop edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mCnt <= '0;
            mRun <= 1'b0;
        end else if (o_tmr_clear) begin
            mCnt <= '0;
            mRun <= 1'b0;
        end else if (o_tmr_start) begin
            mRun <= 1'b1;
        end else if (o_tmr_stop) begin
            mRun <= 1'b0;
        end else if (mRun) begin
            mCnt <= mCnt + 16'd1;
        end
    end
    assign i_tmr_elapsed = mCnt;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] reqValue, input logic readyValue);
        @(posedge clk);
        #1;
        i_req       = reqValue;
        i_res_ready = readyValue;
    endtask

    task automatic pushExp(input int id, input int to, input int lo, input int hi);
        exp_t e;
        e.id = id; e.to = to; e.lo = lo; e.hi = hi;
        sb.push_back(e);
    endtask

    // Result monitor: pops one expectation per accepted result; also watches pulse rules.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("pulse_exclusive",
                        32'(o_tmr_start) + 32'(o_tmr_stop) + 32'(o_tmr_clear) <= 1, 1);
            checkOutput("clear_in_report", 32'(o_tmr_clear && o_res_valid), 0);
            if (o_res_valid && i_res_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_result", 1, 0);
                end else begin
                    popped = sb.pop_front();
                    checkOutput("res_id", 32'(o_res_id), popped.id);
                    checkOutput("res_timeout", 32'(o_res_timeout), popped.to);
                    checkOutput("res_count_model", 32'(o_res_count), 32'(mCnt));
                    checkOutput("res_count_range",
                                32'(int'(o_res_count) >= popped.lo && int'(o_res_count) <= popped.hi), 1);
                end
            end
        end
    end

    task automatic waitGntValue(input string tag, input logic [3:0] wantZero);
        int c = 0;
        while (((wantZero != 0) ? (o_gnt != 0) : (o_gnt == 0)) && c < 200) begin
            @(negedge clk);
            c++;
        end
        checkOutput(tag, 32'(c < 200), 1);
    endtask

    task automatic drainScoreboard(input string tag);
        int c = 0;
        while (sb.size() != 0 && c < 300) begin
            @(negedge clk);
            c++;
        end
        checkOutput(tag, sb.size(), 0);
    endtask

    initial begin
        logic [15:0] heldCount;
        logic [3:0]  dropMask;
        int          c;
        int          expId;
        rst         = 1'b1;
        i_req       = '0;
        i_res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_gnt", 32'(o_gnt), 0);
        checkOutput("rst_pulses", 32'({o_tmr_start, o_tmr_stop, o_tmr_clear}), 0);
        checkOutput("rst_valid", 32'(o_res_valid), 0);
        checkOutput("rst_result", 32'({o_res_id, o_res_count, o_res_timeout}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] fairness");
        applyStimulus(4'b1111, 1'b1);
        for (int k = 0; k < 5; k++) begin
            expId = k % 4;
            waitGntValue("fair_wait_gnt", 4'b0000);
            checkOutput("fair_gnt", 32'(o_gnt), 32'(1) << expId);
            pushExp(expId, 0, 1, 65535);
            applyStimulus(4'b1111, 1'b1);
            applyStimulus(4'b1111, 1'b1);
            dropMask = 4'b1111 & ~(4'b0001 << expId);
            applyStimulus(dropMask, 1'b1);
            waitGntValue("fair_wait_release", 4'b0001);
            applyStimulus(4'b1111, 1'b1);
        end
        applyStimulus(4'b0000, 1'b1);
        drainScoreboard("fair_drain");

        $display("[TB] single request");
        pushExp(0, 0, 8, 8);
        applyStimulus(4'b0001, 1'b1);
        @(negedge clk);
        checkOutput("single_idle_gnt", 32'(o_gnt), 0);
        @(negedge clk);
        checkOutput("single_clear", 32'({o_tmr_clear, o_tmr_start, o_tmr_stop}), 3'b100);
        checkOutput("single_clear_gnt", 32'(o_gnt), 4'b0001);
        @(negedge clk);
        checkOutput("single_start", 32'({o_tmr_clear, o_tmr_start, o_tmr_stop}), 3'b010);
        checkOutput("single_start_gnt", 32'(o_gnt), 4'b0001);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checkOutput("single_run_gnt", 32'({o_gnt, o_tmr_stop}), 5'b00010);
        end
        applyStimulus(4'b0000, 1'b1);
        @(negedge clk);
        checkOutput("single_last_run", 32'({o_gnt, o_tmr_stop}), 5'b00010);
        @(negedge clk);
        checkOutput("single_stop", 32'({o_gnt, o_tmr_stop}), 5'b00001);
        @(negedge clk);
        checkOutput("single_valid", 32'(o_res_valid), 1);
        drainScoreboard("single_drain");

        $display("[TB] early drop");
        pushExp(2, 0, 1, 2);
        applyStimulus(4'b0100, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("early_clear", 32'(o_tmr_clear), 1);
        applyStimulus(4'b0000, 1'b1);
        @(negedge clk);
        checkOutput("early_start", 32'(o_tmr_start), 1);
        @(negedge clk);
        checkOutput("early_run", 32'({o_gnt, o_tmr_stop}), 5'b01000);
        @(negedge clk);
        checkOutput("early_stop", 32'(o_tmr_stop), 1);
        drainScoreboard("early_drain");

        $display("[TB] backpressure");
        pushExp(3, 0, 1, 65535);
        repeat (5) applyStimulus(4'b1000, 1'b0);
        applyStimulus(4'b0010, 1'b0);
        c = 0;
        while (!o_res_valid && c < 50) begin
            @(negedge clk);
            c++;
        end
        checkOutput("bp_wait_valid", 32'(o_res_valid), 1);
        heldCount = o_res_count;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_hold_valid", 32'(o_res_valid), 1);
            checkOutput("bp_hold_id", 32'(o_res_id), 3);
            checkOutput("bp_hold_count", 32'(o_res_count), 32'(heldCount));
            checkOutput("bp_no_clear", 32'(o_tmr_clear), 0);
        end
        pushExp(1, 0, 1, 65535);
        applyStimulus(4'b0010, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp_turn_idle", 32'({o_tmr_clear, o_res_valid}), 0);
        @(negedge clk);
        checkOutput("bp_turn_clear", 32'({o_tmr_clear, o_gnt}), 5'b10010);
        repeat (3) applyStimulus(4'b0010, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        drainScoreboard("bp_drain");

`ifdef STOPWATCH_ARBITER_TIMEOUT_EN
        $display("[TB] timeout enabled");
        pushExp(1, 1, 20, 22);
        applyStimulus(4'b0010, 1'b1);
        c = 0;
        while (!o_res_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        checkOutput("to_forced_stop", 32'(o_res_valid), 1);
        applyStimulus(4'b0000, 1'b1);
        drainScoreboard("to_drain");
`else
        $display("[TB] timeout disabled");
        pushExp(1, 0, 30, 65535);
        for (int k = 0; k < 40; k++) begin
            applyStimulus(4'b0010, 1'b1);
            if (k >= 4) begin
                @(negedge clk);
                checkOutput("no_forced_stop", 32'({o_gnt, o_tmr_stop, o_res_valid}), 6'b001000);
            end
        end
        applyStimulus(4'b0000, 1'b1);
        drainScoreboard("nto_drain");
`endif

        $display("[TB] reset mid-run");
        applyStimulus(4'b1001, 1'b1);
        waitGntValue("rst_wait_gnt", 4'b0000);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_gnt", 32'(o_gnt), 0);
        checkOutput("midrst_pulses", 32'({o_tmr_start, o_tmr_stop, o_tmr_clear}), 0);
        checkOutput("midrst_result", 32'({o_res_valid, o_res_id, o_res_count, o_res_timeout}), 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        pushExp(0, 0, 1, 65535);
        @(negedge clk);
        @(negedge clk);
        checkOutput("midrst_ptr0", 32'(o_gnt), 4'b0001);
        repeat (3) applyStimulus(4'b1001, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        drainScoreboard("midrst_drain");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/stopwatch_arbiter.md
# stopwatch_arbiter

Shares a single `StopTimer` stopwatch among `NUM_REQ` requesters that each need an exclusive elapsed-cycle measurement. A round-robin controller grants one requester at a time and drives the stopwatch's `start`, `stop` and `clear` command pulses. It captures the final count and returns it through a valid/ready result port. It sits between the requesting blocks and one `StopTimer` instance.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `TIMEOUT`, 16'hFFF0: elapsed value that forces a stop. Used only when timeout is compiled in.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high; clock `clk`.
- `req` input NUM_REQ: level request; the owner holds it high for the whole measurement window.
- `gnt` output NUM_REQ: one-hot grant, or all zero.
- `tmr_start` output 1: one-cycle start pulse to the stopwatch.
- `tmr_stop` output 1: one-cycle stop pulse to the stopwatch.
- `tmr_clear` output 1: one-cycle clear pulse to the stopwatch.
- `tmr_elapsed` input 16: stopwatch count.
- `res_valid` output 1: result available.
- `res_ready` input 1: consumer accepts the result.
- `res_id` output $clog2(NUM_REQ): index of the measured requester.
- `res_count` output 16: captured elapsed value.
- `res_timeout` output 1: the measurement was ended by timeout.

## Operation
- States: IDLE, CLEAR, START, RUN, STOP, REPORT.
- **IDLE:** if any `req` is high, the round-robin winner is latched as the owner and the FSM goes to CLEAR. Search starts at the pointer; the pointer is 0 after reset.
- **CLEAR:** `tmr_clear`=1 for this cycle; `gnt[owner]`=1 from this state onward. Go to START.
- **START:** `tmr_start`=1 for this cycle. Go to RUN.
- **RUN:** hold `gnt`. Go to STOP when either:
  - `req[owner]`==0, or
  - the timeout fires (`tmr_elapsed` >= `TIMEOUT`). In that case latch the timeout flag.
- **STOP:** `tmr_stop`=1 for this cycle, `gnt`=0. Go to REPORT.
- **REPORT:**
  - On entry, `res_count`←`tmr_elapsed` (the stopwatch count is stable after the stop edge), `res_id`←owner, and `res_valid`=1.
  - Hold all result fields stable until the cycle where `res_valid`&&`res_ready`.
  - On that cycle: go to IDLE and set the pointer to owner+1, wrapping NUM_REQ-1→0.
- Only one command pulse is ever high in a cycle. Command pulses are registered outputs.
- `req[owner]` falling during CLEAR or START is not acted on early. START is still issued, and RUN exits on its first cycle. The count is then small but nonzero.
- Requests from non-owners are ignored until IDLE. They are never lost, because `req` is level-sensitive.
- Count arithmetic is 16-bit unsigned; there is no saturation in this block.

## Timing
- Reset values: `gnt`=0, all `tmr_*` outputs=0, `res_valid`=0, `res_id`=0, `res_count`=0, `res_timeout`=0. FSM=IDLE, pointer=0.
- From `req` rising in IDLE:
  - cycle +1: `tmr_clear`;
  - cycle +2: `tmr_start`;
  - cycle +3 onward: RUN.
- From `req[owner]` falling in RUN:
  - cycle +1: `tmr_stop`;
  - cycle +2: `res_valid`.
- Measurement turnaround (result accepted to next `tmr_clear`) is a minimum of 2 cycles.
- `rst` mid-operation returns everything to reset values immediately. The stopwatch is expected to share `rst`.

## Configuration
- `STOPWATCH_ARBITER_TIMEOUT_EN` defined: the timeout compare is active in RUN. `res_timeout` reports whether the timeout ended the measurement.
- `STOPWATCH_ARBITER_TIMEOUT_EN` undefined:
  - no comparator;
  - RUN exits only on `req[owner]` deasserting;
  - `res_timeout` is tied 0;
  - `TIMEOUT` is unused.

## Structure
- Package `stopwatch_arbiter_pkg` holds:
  - the state enum `sa_state_t`, 3-bit;
  - the count width constant `SA_CNT_W`=16.
- Sub-module `rr_arbiter` (parameter `NUM_REQ`) takes the request vector and pointer and returns the winner index plus an any-request flag. It is purely combinational. The FSM, registers and result port live in the top module.

## Test plan
- **Single request:** `req[0]` high for 10 cycles, with a behavioural `StopTimer` attached, then dropped. Expect clear, start and stop each one cycle in order; `res_valid` with `res_id`=0 and `res_count` equal to the model count; `gnt[0]` high CLEAR..RUN only.
- **Fairness:** all `req` held high with `res_ready`=1. Expect grants in order 0,1,2,3,0. Expect one result per grant, with `res_id` matching.
- **Backpressure:** `res_ready`=0 for 5 cycles in REPORT. Expect `res_valid`, `res_id` and `res_count` to hold. No new `tmr_clear` is issued until the handshake completes.
- **Early drop:** `req[2]` drops during the START cycle. Expect STOP issued on the first RUN cycle and a small count (1–2).
- **Timeout (macro defined, `TIMEOUT`=20):** `req[1]` held high. Expect a forced stop with `res_timeout`=1 and `res_count`>=20. With the macro undefined, no forced stop occurs.
- **Reset mid-RUN:** assert `rst` while in RUN. Expect all outputs 0 immediately. After reset, the pointer restarts at requester 0.
